// File: rtl/receiver_rsa_query_if.sv
// Handshake and data bundle between the query-generation engine and whoever
// launches it. The master side supplies the start request and operands;
// the slave side (the engine) returns the query value and status.
interface receiver_rsa_query_if;
  logic        gen;
  logic        choice;
  logic [31:0] k;
  logic [31:0] e;
  logic [31:0] N;
  logic [31:0] rand_val0;
  logic [31:0] rand_val1;
  logic [31:0] received_data;
  logic        gen_end;
  logic        busy;

  // Requester view: drives operands and start, observes result and status
  modport master (
    output gen, choice, k, e, N, rand_val0, rand_val1,
    input  received_data, gen_end, busy
  );

  // Engine view: consumes operands and start, produces result and status
  modport slave (
    input  gen, choice, k, e, N, rand_val0, rand_val1,
    output received_data, gen_end, busy
  );
endinterface

// File: rtl/receiver_rsa_query.sv
// Receiver-side query generator for an oblivious-transfer style exchange.
// Produces received_data = (x + k^e mod N) mod N with x selected by choice.
// The modular exponentiation is right-to-left square-and-multiply where every
// modular product is formed bit-serially (MSB first, one multiplier bit per
// clock), so a run always takes exactly 2049 clocks after the start edge,
// independent of the operand values.
module receiver_rsa_query (
  input  logic                 clk,
  input  logic                 rst,
  receiver_rsa_query_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_R = 2'd1,
    MUL_B = 2'd2,
    ADD   = 2'd3
  } state_t;

  state_t      state_q;

  // Operands captured at the start edge so later input changes are harmless
  logic [31:0] x_q;
  logic [31:0] e_q;
  logic [31:0] n_q;

  // Exponentiation working values
  logic [31:0] base_q;
  logic [31:0] result_q;

  // Bit-serial multiply accumulator, multiplier bit counter, exponent bit index
  logic [31:0] r_q;
  logic [4:0]  cnt_q;
  logic [4:0]  bit_q;

  // Registered outputs
  logic [31:0] data_q;
  logic        genEnd_q;
  logic        busy_q;

  // Combinational helpers for one multiply step and for the final add
  logic [31:0] multiplier;
  logic        mulBit;
  logic [33:0] nWide;
  logic [33:0] dblStep;
  logic [33:0] addStep;
  logic [31:0] r_d;
  logic [32:0] addSum;
  logic [32:0] addRes;

  // One step of the shift-and-add modular multiply: r = 2r mod N, then
  // conditionally r = r + base mod N. Both multiplies use base as the
  // addend; MUL_R walks the bits of result, MUL_B walks the bits of base.
  // Inputs to each step stay below N, so a single conditional subtract
  // after each operation keeps r reduced; 34 bits cover 2r and r+base.
  always_comb begin
    multiplier = (state_q == MUL_R) ? result_q : base_q;
    mulBit     = multiplier[5'd31 - cnt_q];
    nWide      = {2'b00, n_q};
    dblStep    = {1'b0, r_q, 1'b0};
    if (dblStep >= nWide) begin
      dblStep = dblStep - nWide;
    end
    addStep = dblStep;
    if (mulBit) begin
      addStep = dblStep + {2'b00, base_q};
    end
    if (addStep >= nWide) begin
      addStep = addStep - nWide;
    end
    r_d = addStep[31:0];
  end

  // Final blinding add: s = x + result, reduced once modulo N in 33 bits
  always_comb begin
    addSum = {1'b0, x_q} + {1'b0, result_q};
    addRes = addSum;
    if (addSum >= {1'b0, n_q}) begin
      addRes = addSum - {1'b0, n_q};
    end
  end

  // Control FSM and datapath registers; all outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= 32'd0;
      e_q      <= 32'd0;
      n_q      <= 32'd0;
      base_q   <= 32'd0;
      result_q <= 32'd0;
      r_q      <= 32'd0;
      cnt_q    <= 5'd0;
      bit_q    <= 5'd0;
      data_q   <= 32'd0;
      genEnd_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      genEnd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.gen) begin
            x_q      <= bus.choice ? bus.rand_val1 : bus.rand_val0;
            e_q      <= bus.e;
            n_q      <= bus.N;
            base_q   <= bus.k;
            result_q <= 32'd1;
            r_q      <= 32'd0;
            cnt_q    <= 5'd0;
            bit_q    <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= MUL_R;
          end
        end

        MUL_R: begin
          r_q   <= r_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            // The product is always formed; it is kept only for a set bit
            r_q <= 32'd0;
            if (e_q[bit_q]) begin
              result_q <= r_d;
            end
            state_q <= MUL_B;
          end
        end

        MUL_B: begin
          r_q   <= r_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            r_q    <= 32'd0;
            base_q <= r_d;
            bit_q  <= bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              state_q <= ADD;
            end else begin
              state_q <= MUL_R;
            end
          end
        end

        ADD: begin
          data_q   <= addRes[31:0];
          genEnd_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.received_data = data_q;
  assign bus.gen_end       = genEnd_q;
  assign bus.busy          = busy_q;

endmodule

// File: doc/receiver_rsa_query.md
RECEIVER_RSA_QUERY -- requirements
Module: receiver_rsa_query

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: gen  input  1  start request, level-sampled in IDLE.
REQ-004 SHALL have port: choice  input  1  selects rand_val0 (0) or rand_val1 (1).
REQ-005 SHALL have ports: k, e, N, rand_val0, rand_val1  input  32 each  blinding value, public exponent, modulus, sender random values.
REQ-006 SHALL have port: received_data  output  32  query value sent to the sender-side packing stage.
REQ-007 SHALL have port: gen_end  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: busy  output  1  high in every state other than IDLE.

Function
REQ-009 SHALL compute received_data = (x + k^e mod N) mod N, where x = choice ? rand_val1 : rand_val0.
REQ-010 SHALL use states IDLE, MUL_R, MUL_B and ADD only.
REQ-011 SHALL, in IDLE with gen=1 at edge T, do the following: capture all inputs; set result=1 and base=k; set the exponent bit index to 0; go to MUL_R.
REQ-012 SHALL compute each modular multiply bit-serially, multiplier MSB first, one bit per edge, 32 edges per multiply, with r=0 at start.
REQ-013 Each multiply step SHALL: set r=2r, subtract N if r>=N; then, if the multiplier bit is 1, set r=r+a and subtract N if r>=N. Intermediates SHALL be 34 bits wide.
REQ-014 MUL_R SHALL compute result*base mod N. Its output SHALL be written to result only when exponent bit i is 1; it SHALL still take 32 edges when the bit is 0 (constant time).
REQ-015 MUL_B SHALL compute base*base mod N in 32 edges, then increment i. After i=31 it SHALL go to ADD; otherwise it SHALL go to MUL_R.
REQ-016 All 32 exponent bits SHALL be processed regardless of the value of e; there is no early exit.
REQ-017 ADD (one edge) SHALL do the following: form the 33-bit sum s = x + result; register s-N if s>=N, else s[31:0], into received_data; assert gen_end; go to IDLE.
REQ-018 gen_end SHALL be high exactly in the cycle following edge T+2049, and SHALL be low otherwise.
REQ-019 received_data SHALL hold its value until the next ADD or reset.
REQ-020 gen SHALL be ignored outside IDLE. gen held high SHALL start a new run on the edge after gen_end falls back to IDLE sampling.
REQ-021 Input changes after edge T SHALL NOT affect the running computation.
REQ-022 Preconditions are k<N, x<N and N>=2; N=0 is not supported.
REQ-023 With N=1, received_data SHALL be 0.
REQ-024 With e=0, the exponent term SHALL be 1.
REQ-025 Outside the preconditions the result is unspecified, but the REQ-018 timing SHALL still hold.

Reset
REQ-026 On rst=1, the block SHALL immediately do the following: go to IDLE; clear received_data, gen_end and busy to 0; clear all internal registers to 0.
REQ-027 Reset mid-operation SHALL abort the run with no gen_end pulse.
REQ-028 The first gen sampled after rst deasserts SHALL start a fresh run.

Verification
REQ-029 Bench SHALL run: k=4, e=13, N=497, rand_val0=10, choice=0 -> received_data=455, gen_end one cycle after edge T+2049.
REQ-030 Bench SHALL run: same inputs, choice=1, rand_val1=100 -> received_data=48 (wrap case 545-497).
REQ-031 Bench SHALL run: k=65, e=17, N=3233, rand_val1=500, choice=1 -> received_data=57 (65^17 mod 3233=2790).
REQ-032 Bench SHALL run: e=0, k=7, N=11, rand_val0=3, choice=0 -> received_data=4. Latency SHALL be unchanged at 2049 edges.
REQ-033 Bench SHALL run: gen pulsed again at edge T+500 and inputs changed mid-run -> run unaffected; exactly one gen_end; busy=1 from T+1 through the ADD edge.
REQ-034 Bench SHALL run: rst asserted at edge T+1000 -> outputs 0 immediately, no gen_end. A new gen after release -> correct result after 2049 edges.
